// File: rtl/usc_pkg.sv
// Shared definitions for the universal shift/count register: mode encodings
// and the 3-bit mode type used at the mode port.
package usc_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'b000,
    SHR  = 3'b001,
    SHL  = 3'b010,
    LOAD = 3'b011,
    ROR  = 3'b100,
    ROL  = 3'b101,
    CUP  = 3'b110,
    CDN  = 3'b111
  } usc_mode_e;

  localparam int unsigned USC_MODE_W = 3;

endpackage : usc_pkg

// File: rtl/univ_shift_counter.sv
// Universal register: hold, serial shift, parallel load, rotate and up/down
// count selected by mode, gated by en, with a combinational terminal-count flag.
module univ_shift_counter
  import usc_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                  CLK,
  input  logic                  clr,
  input  logic                  en,
  input  logic [USC_MODE_W-1:0] mode,
  input  logic                  MSB_in,
  input  logic                  LSB_in,
  input  logic [WIDTH-1:0]      reg_in,
  output logic [WIDTH-1:0]      reg_out,
  output logic                  tc
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;
  usc_mode_e        w_mode;

  assign w_mode = usc_mode_e'(mode);

  always_comb begin
    w_next = r_state;
    if (en) begin
      unique case (w_mode)
        HOLD: w_next = r_state;
        SHR:  w_next = {MSB_in, r_state[WIDTH-1:1]};
        SHL:  w_next = {r_state[WIDTH-2:0], LSB_in};
        LOAD: w_next = reg_in;
        ROR:  w_next = {r_state[0], r_state[WIDTH-1:1]};
        ROL:  w_next = {r_state[WIDTH-2:0], r_state[WIDTH-1]};
        CUP:  w_next = r_state + 1'b1;
        CDN:  w_next = r_state - 1'b1;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) r_state <= RST_VAL;
    else      r_state <= w_next;
  end

  assign reg_out = r_state;

  // Flags the cycle whose edge will wrap the count in the selected direction.
  assign tc = en && (((w_mode == CUP) && (r_state == '1)) ||
                     ((w_mode == CDN) && (r_state == '0)));

endmodule : univ_shift_counter

// File: tb/tb_univ_shift_counter.sv
// Self-checking bench for univ_shift_counter: vector table through a
// scoreboard, async-reset sequence, and WIDTH=2/32 all-ones reset sweep.
module tb_univ_shift_counter;
  import usc_pkg::*;

  logic        CLK;
  logic        clr;
  logic        en;
  logic [2:0]  mode;
  logic        MSB_in;
  logic        LSB_in;
  logic [7:0]  rin8;
  logic [7:0]  out8;
  logic        tc8;
  logic [1:0]  rin2;
  logic [1:0]  out2;
  logic        tc2;
  logic [31:0] rin32;
  logic [31:0] out32;
  logic        tc32;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [7:0] sb[$];

  univ_shift_counter #(.WIDTH(8), .RST_VAL(8'h00)) dut8 (
    .CLK(CLK), .clr(clr), .en(en), .mode(mode), .MSB_in(MSB_in),
    .LSB_in(LSB_in), .reg_in(rin8), .reg_out(out8), .tc(tc8)
  );

  univ_shift_counter #(.WIDTH(2), .RST_VAL(2'b11)) dut2 (
    .CLK(CLK), .clr(clr), .en(en), .mode(mode), .MSB_in(MSB_in),
    .LSB_in(LSB_in), .reg_in(rin2), .reg_out(out2), .tc(tc2)
  );

  univ_shift_counter #(.WIDTH(32), .RST_VAL(32'hFFFF_FFFF)) dut32 (
    .CLK(CLK), .clr(clr), .en(en), .mode(mode), .MSB_in(MSB_in),
    .LSB_in(LSB_in), .reg_in(rin32), .reg_out(out32), .tc(tc32)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic       msb;
    logic       lsb;
    logic [7:0] rin;
    logic       etc;
    logic [7:0] eout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop_chk(input string name);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=empty_queue required=entry", name);
    end else begin
      chk(name, {24'h0, out8}, {24'h0, sb.pop_front()});
    end
  endtask

  // Drive one cycle: check tc before the edge, queue expected reg_out, compare after.
  task automatic step(input vec_t v, input string name);
    @(negedge CLK);
    en = v.en; mode = v.mode; MSB_in = v.msb; LSB_in = v.lsb; rin8 = v.rin;
    #1;
    chk({name, "_tc"}, {31'h0, tc8}, {31'h0, v.etc});
    sb.push_back(v.eout);
    @(posedge CLK);
    #1;
    sb_pop_chk({name, "_out"});
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; mode = HOLD; MSB_in = 1'b0; LSB_in = 1'b0;
    rin8 = '0; rin2 = '0; rin32 = '0;
    #1 clr = 1'b0;
    #1;
    chk("rst8_async", {24'h0, out8}, 32'h0);
    chk("rst8_tc", {31'h0, tc8}, 32'h0);
    chk("rst2_async", {30'h0, out2}, 32'h3);
    chk("rst32_async", out32, 32'hFFFF_FFFF);
    repeat (2) @(posedge CLK);
    @(negedge CLK) clr = 1'b1;

    //            en    mode  msb   lsb   rin    tc    out
    vecs.push_back('{1'b1, LOAD, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5});
    vecs.push_back('{1'b1, SHR,  1'b1, 1'b0, 8'h00, 1'b0, 8'hD2});
    vecs.push_back('{1'b1, SHL,  1'b0, 1'b0, 8'h00, 1'b0, 8'hA4});
    vecs.push_back('{1'b1, LOAD, 1'b0, 1'b0, 8'h81, 1'b0, 8'h81});
    vecs.push_back('{1'b1, ROR,  1'b0, 1'b0, 8'h00, 1'b0, 8'hC0});
    vecs.push_back('{1'b1, ROL,  1'b0, 1'b0, 8'h00, 1'b0, 8'h81});
    vecs.push_back('{1'b1, ROL,  1'b0, 1'b0, 8'h00, 1'b0, 8'h03});
    vecs.push_back('{1'b1, LOAD, 1'b0, 1'b0, 8'hFE, 1'b0, 8'hFE});
    vecs.push_back('{1'b1, CUP,  1'b0, 1'b0, 8'h00, 1'b0, 8'hFF});
    vecs.push_back('{1'b1, CUP,  1'b0, 1'b0, 8'h00, 1'b1, 8'h00});
    vecs.push_back('{1'b1, CDN,  1'b0, 1'b0, 8'h00, 1'b1, 8'hFF});
    vecs.push_back('{1'b1, CDN,  1'b0, 1'b0, 8'h00, 1'b0, 8'hFE});
    vecs.push_back('{1'b1, LOAD, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h3C});
    for (int m = 0; m < 8; m++)
      vecs.push_back('{1'b0, 3'(m), 1'b1, 1'b1, 8'hFF, 1'b0, 8'h3C});
    vecs.push_back('{1'b1, LOAD, 1'b0, 1'b0, 8'hFF, 1'b0, 8'hFF});
    vecs.push_back('{1'b0, CUP,  1'b0, 1'b0, 8'h00, 1'b0, 8'hFF});
    vecs.push_back('{1'b1, LOAD, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{1'b0, CDN,  1'b0, 1'b0, 8'h55, 1'b0, 8'h00});
    // Serial and parallel inputs driven where they must be ignored.
    vecs.push_back('{1'b1, LOAD, 1'b1, 1'b1, 8'h0F, 1'b0, 8'h0F});
    vecs.push_back('{1'b1, ROR,  1'b0, 1'b0, 8'h00, 1'b0, 8'h87});
    vecs.push_back('{1'b1, HOLD, 1'b1, 1'b1, 8'hAA, 1'b0, 8'h87});
    vecs.push_back('{1'b1, CUP,  1'b1, 1'b1, 8'hFF, 1'b0, 8'h88});
    vecs.push_back('{1'b1, SHR,  1'b0, 1'b1, 8'hFF, 1'b0, 8'h44});
    vecs.push_back('{1'b1, SHL,  1'b0, 1'b1, 8'h00, 1'b0, 8'h89});
    vecs.push_back('{1'b1, ROL,  1'b1, 1'b0, 8'hFF, 1'b0, 8'h13});

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Async reset in the middle of counting up.
    step('{1'b1, LOAD, 1'b0, 1'b0, 8'h56, 1'b0, 8'h56}, "ar_load");
    step('{1'b1, CUP,  1'b0, 1'b0, 8'h00, 1'b0, 8'h57}, "ar_cup");
    @(negedge CLK);
    en = 1'b1; mode = CUP;
    clr = 1'b0;
    #1;
    chk("ar_immediate", {24'h0, out8}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      sb.push_back(8'h00);
      @(posedge CLK);
      #1;
      sb_pop_chk($sformatf("ar_hold%0d", k));
    end
    @(negedge CLK);
    clr = 1'b1;
    sb.push_back(8'h01);
    @(posedge CLK);
    #1;
    sb_pop_chk("ar_first_edge");

    // WIDTH=2 / WIDTH=32 all-ones reset and wrap.
    @(negedge CLK);
    en = 1'b0; mode = HOLD;
    clr = 1'b0;
    #1;
    chk("sw2_rst", {30'h0, out2}, 32'h3);
    chk("sw32_rst", out32, 32'hFFFF_FFFF);
    @(negedge CLK);
    clr = 1'b1; en = 1'b1; mode = CUP;
    #1;
    chk("sw2_tc_pre", {31'h0, tc2}, 32'h1);
    chk("sw32_tc_pre", {31'h0, tc32}, 32'h1);
    @(posedge CLK);
    #1;
    chk("sw2_wrap", {30'h0, out2}, 32'h0);
    chk("sw32_wrap", out32, 32'h0);
    chk("sw2_tc_post", {31'h0, tc2}, 32'h0);
    chk("sw32_tc_post", {31'h0, tc32}, 32'h0);
    @(posedge CLK);
    #1;
    chk("sw2_next", {30'h0, out2}, 32'h1);
    chk("sw32_next", out32, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_univ_shift_counter

// File: doc/univ_shift_counter.md
UNIV_SHIFT_COUNTER -- requirements
Module: univ_shift_counter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the register width in bits, legal range 2..32.
REQ-002 Parameter RST_VAL, default 0, SHALL set the value loaded into reg_out on reset, WIDTH bits wide.
REQ-003 Port CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port clr  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port en  input  1  SHALL gate all mode operations; en=0 holds state.
REQ-006 Port mode  input  3  SHALL select the operation per REQ-012.
REQ-007 Port MSB_in  input  1  SHALL be the serial input entering bit WIDTH-1 on a right shift.
REQ-008 Port LSB_in  input  1  SHALL be the serial input entering bit 0 on a left shift.
REQ-009 Port reg_in  input  WIDTH  SHALL be the parallel load data.
REQ-010 Port reg_out  output  WIDTH  SHALL be the registered state.
REQ-011 Port tc  output  1  SHALL be the combinational terminal-count flag per REQ-015.

Function
REQ-012 With en=1, mode SHALL select the next reg_out as follows:
- 000: hold.
- 001: shift right, {MSB_in, reg_out[WIDTH-1:1]}.
- 010: shift left, {reg_out[WIDTH-2:0], LSB_in}.
- 011: parallel load of reg_in.
- 100: rotate right, {reg_out[0], reg_out[WIDTH-1:1]}.
- 101: rotate left, {reg_out[WIDTH-2:0], reg_out[WIDTH-1]}.
- 110: count up, reg_out+1, modulo 2^WIDTH.
- 111: count down, reg_out-1, modulo 2^WIDTH.
REQ-013 Latency SHALL be exactly one CLK edge: inputs sampled at edge N appear on reg_out immediately after edge N.
REQ-014 Count wrap SHALL be silent: all-ones+1 gives 0, and 0-1 gives all-ones; there is no saturation.
REQ-015 tc SHALL be 1 iff en=1 and either (mode=110 and reg_out is all-ones) or (mode=111 and reg_out=0); otherwise 0.
REQ-016 en=0 SHALL force tc=0 and hold reg_out regardless of mode and all other inputs.
REQ-017 Serial inputs SHALL be ignored in every mode except 001 (MSB_in) and 010 (LSB_in).
REQ-018 reg_in SHALL be ignored in every mode except 011.
REQ-019 A mode change between consecutive edges SHALL take effect on the next edge with no idle cycle.

Reset
REQ-020 clr=0 SHALL immediately, without waiting for CLK, force reg_out=RST_VAL, and consequently tc evaluates from that value.
REQ-021 Reset SHALL dominate en, mode and any CLK edge arriving while clr=0.
REQ-022 After clr deasserts, the first rising CLK edge SHALL perform a normal operation.
REQ-023 Reset asserted mid-count or mid-shift SHALL discard the operation in progress with no residual state.

Structure
REQ-024 The mode encodings (HOLD, SHR, SHL, LOAD, ROR, ROL, CUP, CDN) SHALL be named constants in the shared package usc_pkg, together with a 3-bit mode typedef.
REQ-025 The block SHALL be a single module with one state register and no sub-modules.
REQ-026 Next-state logic SHALL be purely combinational from reg_out and inputs, and the state register SHALL be the only storage.

Verification (WIDTH=8, RST_VAL=0)
REQ-027 Load and shift: mode=011 with reg_in=0xA5, then mode=001 with MSB_in=1 -> reg_out 0xA5 then 0xD2; then mode=010 with LSB_in=0 -> 0xA4.
REQ-028 Rotate: load 0x81, then mode=100 -> 0xC0; then mode=101 twice -> 0x81, then 0x03.
REQ-029 Count wrap and tc: load 0xFE, then mode=110 -> reg_out 0xFF with tc=1; next edge -> 0x00 with tc=0; then mode=111 -> tc=1 before the edge, 0xFF after it.
REQ-030 Enable: load 0x3C, then en=0 with each mode 000..111 applied for one edge -> reg_out remains 0x3C and tc=0 throughout.
REQ-031 Async reset: counting up at 0x57, drive clr low between edges -> reg_out=0x00 before the next edge, held low through 3 edges at 0x00; first edge after release with mode=110 -> 0x01.
REQ-032 Parameter sweep: WIDTH=2 and WIDTH=32 with RST_VAL=all-ones -> reset value all-ones, and count-up wraps to 0 with tc=1 on the preceding cycle.
